// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU operation codes
// and FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unknown opcodes yield a zero
// result and raise err.
import alu_arbiter_pkg::*;

module alu_arbiter_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (sel)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  result = ~(a | b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: IDLE grants, EXEC computes,
// DONE holds the response. Define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; the response transfers on a rising edge where
// resp_valid and resp_ready are both high. resp_* outputs hold while waiting.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] op1_0,
  input  logic [WIDTH-1:0] op2_0,
  input  logic [WIDTH-1:0] op1_1,
  input  logic [WIDTH-1:0] op2_1,
  input  logic [3:0]       selOp_0,
  input  logic [3:0]       selOp_1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resultado,
  output logic             zeroFlag,
  output logic             resp_err,
  output logic [1:0]       dbg_state
);

  state_t           state;
  logic             gnt_any;
  logic             gnt_id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       sel_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

`ifdef ALU_ARB_RR_EN
  logic ptr;

  // On contention the pointer decides; a lone requester always wins.
  always_comb begin
    gnt_id = req_valid[1];
    if (req_valid == 2'b11) gnt_id = ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (gnt_any) ptr <= ~gnt_id;
  end
`else
  assign gnt_id = ~req_valid[0];
`endif

  assign gnt_any   = (state == ST_IDLE) && (|req_valid) && !rst;
  assign dbg_state = state;

  always_comb begin
    req_ready = 2'b00;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_res),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resultado  <= '0;
      zeroFlag   <= 1'b0;
      resp_err   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      id_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            a_q   <= gnt_id ? op1_1 : op1_0;
            b_q   <= gnt_id ? op2_1 : op2_0;
            sel_q <= gnt_id ? selOp_1 : selOp_0;
            id_q  <= gnt_id;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resultado  <= alu_res;
          zeroFlag   <= (alu_res == '0);
          resp_err   <= alu_err;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, contention/backpressure/reset
// sequences, and randomized traffic against a behavioural ALU/arbiter model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] op1_0, op2_0, op1_1, op2_1;
  logic [3:0]  selOp_0, selOp_1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resultado;
  logic        zeroFlag;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rr_ptr   = 0;

  logic [34:0] exp_q[$];
  logic        exp_id_q[$];

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
    .selOp_0(selOp_0), .selOp_1(selOp_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resultado(resultado), .zeroFlag(zeroFlag), .resp_err(resp_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: the ALU rules stated as plain arithmetic; returns {err, zero, res}.
  function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (s)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = (a < b) ? 32'd1 : 32'd0;
      4'd12:   r = ~(a | b);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  function automatic int ref_grant(input logic [1:0] m);
`ifdef ALU_ARB_RR_EN
    if (m == 2'b11) return rr_ptr;
`endif
    return m[0] ? 0 : 1;
  endfunction

  // driver tasks (all called at a falling edge)
  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s);
    if (id == 0) begin op1_0 = a; op2_0 = b; selOp_0 = s; end
    else         begin op1_1 = a; op2_1 = b; selOp_1 = s; end
    req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
  endtask

  // Waits (bounded) for a grant and checks it; returns at the EXEC falling edge.
  task automatic wait_grant(input logic [1:0] exp_mask, input string name);
    int n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, " grant"}, 32'(req_ready), 32'(exp_mask));
    if (exp_mask == 2'b01) rr_ptr = 1;
    else rr_ptr = 0;
    @(negedge clk);
  endtask

  // From the EXEC edge: check latency, the response, then the handshake.
  task automatic check_resp(input logic id, input logic [31:0] res, input logic zero,
                            input logic err, input string name);
    chk({name, " exec resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, " exec req_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({name, " resultado"}, resultado, res);
    chk({name, " zeroFlag"}, 32'(zeroFlag), 32'(zero));
    chk({name, " resp_err"}, 32'(resp_err), 32'(err));
    chk({name, " resp_id"}, 32'(resp_id), 32'(id));
    chk({name, " done req_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({name, " resp_valid after hs"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd5,          32'd3,          4'b0010, 32'd8,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFFF,   32'd1,          4'b0111, 32'd0,          1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'd0,          32'd1,          4'b0110, 32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h12345678,   32'h9,          4'b1111, 32'd0,          1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'hF0F0F0F0,   32'hFF00FF00,   4'b0000, 32'hF000F000,   1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'hA0000005,   32'h0000000A,   4'b0001, 32'hA000000F,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'd0,          32'd0,          4'b1100, 32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,          4'b0010, 32'd0,          1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'd1,          32'd2,          4'b0111, 32'd1,          1'b0, 1'b0};
    vecs[9] = '{1'b0, 32'h55,         32'h55,         4'b0011, 32'd0,          1'b1, 1'b1};

    req_valid = 2'b11;
    resp_ready = 1'b1;
    op1_0 = '0; op2_0 = '0; op1_1 = '0; op2_1 = '0;
    selOp_0 = '0; selOp_1 = '0;
    rst = 1'b1;

    // reset state, requests present but held off by rst
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_id", 32'(resp_id), 32'd0);
    chk("rst resultado", resultado, 32'd0);
    chk("rst zeroFlag", 32'(zeroFlag), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    rr_ptr = 0;
    @(negedge clk);

    // directed vector table, one requester at a time
    for (int i = 0; i < 10; i++) begin
      set_req(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].s);
      wait_grant(vecs[i].id ? 2'b10 : 2'b01, $sformatf("vec%0d", i));
      req_valid = 2'b00;
      check_resp(vecs[i].id, vecs[i].res, vecs[i].zero, vecs[i].err, $sformatf("vec%0d", i));
    end

    // simultaneous requests from a fresh reset
    do_reset();
    set_req(0, 32'd7, 32'd7, 4'b0110);
    set_req(1, 32'hF0, 32'h0F, 4'b0001);
    wait_grant(2'b01, "sim first");
    check_resp(1'b0, 32'd0, 1'b1, 1'b0, "sim first");
`ifdef ALU_ARB_RR_EN
    wait_grant(2'b10, "sim rr second");
    req_valid = 2'b00;
    check_resp(1'b1, 32'hFF, 1'b0, 1'b0, "sim rr second");
`else
    wait_grant(2'b01, "sim fixed rerequest");
    req_valid[0] = 1'b0;
    check_resp(1'b0, 32'd0, 1'b1, 1'b0, "sim fixed rerequest");
    wait_grant(2'b10, "sim fixed req1");
    req_valid = 2'b00;
    check_resp(1'b1, 32'hFF, 1'b0, 1'b0, "sim fixed req1");
`endif

    // backpressure: hold DONE with another request pending
    resp_ready = 1'b0;
    set_req(0, 32'h10, 32'h20, 4'b0010);
    wait_grant(2'b01, "bp");
    req_valid = 2'b00;
    set_req(1, 32'd1, 32'd2, 4'b0001);
    chk("bp exec resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp hold%0d resultado", k), resultado, 32'h30);
      chk($sformatf("bp hold%0d resp_id", k), 32'(resp_id), 32'd0);
      chk($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'd0);
      if (k < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp resp_valid after hs", 32'(resp_valid), 32'd0);
    wait_grant(2'b10, "bp pending");
    req_valid = 2'b00;
    check_resp(1'b1, 32'd3, 1'b0, 1'b0, "bp pending");

    // reset while in EXEC discards the transaction
    set_req(0, 32'd9, 32'd1, 4'b0010);
    wait_grant(2'b01, "rst exec");
    req_valid = 2'b01;
    rst = 1'b1;
    @(negedge clk);
    chk("rst exec req_ready", 32'(req_ready), 32'd0);
    chk("rst exec resp_valid", 32'(resp_valid), 32'd0);
    chk("rst exec state", 32'(dbg_state), 32'd0);
    chk("rst exec resultado", resultado, 32'd0);
    rst = 1'b0;
    rr_ptr = 0;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst exec no resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("rst exec no resp late", 32'(resp_valid), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  m;
      logic [31:0] a0, b0, a1, b1;
      logic [3:0]  s0, s1, ops[8];
      logic [34:0] e;
      int          g;
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
      m  = 2'($urandom_range(1, 3));
      a0 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      b1 = $urandom;
      s0 = ops[$urandom_range(0, 7)];
      s1 = ops[$urandom_range(0, 7)];
      if (m[0]) set_req(0, a0, b0, s0);
      if (m[1]) set_req(1, a1, b1, s1);
      g = ref_grant(m);
      e = (g == 0) ? ref_alu(a0, b0, s0) : ref_alu(a1, b1, s1);
      exp_q.push_back(e);
      exp_id_q.push_back(g[0]);
      wait_grant((g == 0) ? 2'b01 : 2'b10, $sformatf("rnd%0d", i));
      req_valid = 2'b00;
      e = exp_q.pop_front();
      check_resp(exp_id_q.pop_front(), e[31:0], e[32], e[33], $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
